// File: rtl/axon_spike_scheduler.sv
// Per-core spike delivery buffer: a ring of per-tick axon-activity vectors filled by the router
// and drained one slot per tick by the token controller.
module axon_spike_scheduler #(
  parameter int NUM_AXONS = 256,
  parameter int AXON_W    = 8,
  parameter int NUM_SLOTS = 16,
  parameter int SLOT_W    = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 spike_valid,
  output logic                 spike_ready,
  input  logic [AXON_W-1:0]    spike_axon,
  input  logic [SLOT_W-1:0]    spike_delay,
  input  logic                 read_request,
  output logic [NUM_AXONS-1:0] axon_activity,
  output logic                 activity_valid,
  input  logic                 clear_request,
  output logic                 clear_done,
  output logic [SLOT_W-1:0]    cur_slot,
  output logic                 spike_dropped,
  output logic [CNT_W-1:0]     accepted_count,
  output logic [CNT_W-1:0]     dropped_count
);

  logic [NUM_AXONS-1:0] r_ring [NUM_SLOTS];
  logic [NUM_AXONS-1:0] r_activity;
  logic [SLOT_W-1:0]    r_cur_slot;
  logic                 r_ready;
  logic                 r_activity_valid;
  logic                 r_clear_done;
  logic                 r_spike_dropped;
  logic [CNT_W-1:0]     r_acc_cnt;
  logic [CNT_W-1:0]     r_drop_cnt;

  logic                 w_offer;
  logic                 w_accept;
  logic                 w_reject;
  logic [SLOT_W-1:0]    w_tgt_slot;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Delay 0 would land in the slot the controller may be consuming, so it is rejected.
  assign w_offer    = spike_valid & r_ready;
  assign w_accept   = w_offer & (spike_delay != '0);
  assign w_reject   = w_offer & (spike_delay == '0);
  assign w_tgt_slot = r_cur_slot + spike_delay;

  // Ring storage: clear and write use the pre-edge pointer and never hit the same slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        r_ring[s] <= '0;
      end
    end else begin
      if (clear_request) begin
        r_ring[r_cur_slot] <= '0;
      end
      if (w_accept) begin
        r_ring[w_tgt_slot][spike_axon] <= 1'b1;
      end
    end
  end

  // Latched read copy holds until the next read_request; it sees pre-clear contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_activity       <= '0;
      r_activity_valid <= 1'b0;
    end else begin
      r_activity_valid <= read_request;
      if (read_request) begin
        r_activity <= r_ring[r_cur_slot];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_slot      <= '0;
      r_ready         <= 1'b0;
      r_clear_done    <= 1'b0;
      r_spike_dropped <= 1'b0;
      r_acc_cnt       <= '0;
      r_drop_cnt      <= '0;
    end else begin
      r_ready         <= 1'b1;
      r_clear_done    <= clear_request;
      r_spike_dropped <= w_reject;
      if (tick) begin
        r_cur_slot <= r_cur_slot + SLOT_W'(1);
      end
      if (w_accept) begin
        r_acc_cnt <= sat_inc(r_acc_cnt);
      end
      if (w_reject) begin
        r_drop_cnt <= sat_inc(r_drop_cnt);
      end
    end
  end

  assign spike_ready    = r_ready;
  assign axon_activity  = r_activity;
  assign activity_valid = r_activity_valid;
  assign clear_done     = r_clear_done;
  assign cur_slot       = r_cur_slot;
  assign spike_dropped  = r_spike_dropped;
  assign accepted_count = r_acc_cnt;
  assign dropped_count  = r_drop_cnt;

endmodule

// File: tb/tb_axon_spike_scheduler.sv
// Directed self-checking bench for axon_spike_scheduler.
module tb_axon_spike_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic         spike_valid;
  logic         spike_ready;
  logic [7:0]   spike_axon;
  logic [3:0]   spike_delay;
  logic         read_request;
  logic [255:0] axon_activity;
  logic         activity_valid;
  logic         clear_request;
  logic         clear_done;
  logic [3:0]   cur_slot;
  logic         spike_dropped;
  logic [15:0]  accepted_count;
  logic [15:0]  dropped_count;

  int n_pass = 0;
  int n_total = 0;
  logic [255:0] exp_vec;

  axon_spike_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick),
    .spike_valid(spike_valid), .spike_ready(spike_ready),
    .spike_axon(spike_axon), .spike_delay(spike_delay),
    .read_request(read_request), .axon_activity(axon_activity),
    .activity_valid(activity_valid), .clear_request(clear_request),
    .clear_done(clear_done), .cur_slot(cur_slot),
    .spike_dropped(spike_dropped), .accepted_count(accepted_count),
    .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spike(input logic [7:0] axon, input logic [3:0] dly);
    spike_valid = 1'b1; spike_axon = axon; spike_delay = dly;
    step();
    spike_valid = 1'b0;
  endtask

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
    end
    tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; spike_valid = 1'b0; spike_axon = '0; spike_delay = '0;
    read_request = 1'b0; clear_request = 1'b0;
    step(); step();
    chk("rst_ready", 256'(spike_ready), 256'(0));
    chk("rst_slot", 256'(cur_slot), 256'(0));
    chk("rst_acc", 256'(accepted_count), 256'(0));
    chk("rst_act", axon_activity, 256'(0));
    rst = 1'b0;
    step();
    chk("ready_up", 256'(spike_ready), 256'(1));

    // Test 1: single spike, delay 1
    spike(8'd5, 4'd1);
    chk("t1_acc", 256'(accepted_count), 256'(1));
    do_tick(1);
    chk("t1_slot", 256'(cur_slot), 256'(1));
    read_request = 1'b1; step(); read_request = 1'b0;
    chk("t1_valid", 256'(activity_valid), 256'(1));
    exp_vec = 256'(1) << 5;
    chk("t1_act", axon_activity, exp_vec);
    clear_request = 1'b1; step(); clear_request = 1'b0;
    chk("t1_valid_off", 256'(activity_valid), 256'(0));
    chk("t1_clear_done", 256'(clear_done), 256'(1));

    // Test 2: duplicate spikes merge
    spike(8'd3, 4'd2);
    spike(8'd3, 4'd2);
    chk("t2_acc", 256'(accepted_count), 256'(3));
    do_tick(2);
    read_request = 1'b1; step(); read_request = 1'b0;
    exp_vec = 256'(1) << 3;
    chk("t2_act", axon_activity, exp_vec);
    clear_request = 1'b1; step(); clear_request = 1'b0;

    // Test 3: target slot wraps 14 + 3 -> 1
    do_tick(11);
    chk("t3_slot14", 256'(cur_slot), 256'(14));
    spike(8'd200, 4'd3);
    do_tick(3);
    chk("t3_slot1", 256'(cur_slot), 256'(1));
    read_request = 1'b1; step(); read_request = 1'b0;
    exp_vec = 256'(1) << 200;
    chk("t3_act", axon_activity, exp_vec);

    // Test 4: delay 0 is dropped
    spike(8'd7, 4'd0);
    chk("t4_dropped", 256'(spike_dropped), 256'(1));
    chk("t4_drop_cnt", 256'(dropped_count), 256'(1));
    chk("t4_acc", 256'(accepted_count), 256'(4));
    step();
    chk("t4_dropped_off", 256'(spike_dropped), 256'(0));
    read_request = 1'b1; step(); read_request = 1'b0;
    chk("t4_ring", axon_activity, exp_vec);
    clear_request = 1'b1; step(); clear_request = 1'b0;

    // Test 5: read and clear on the same edge
    for (int a = 0; a < 8; a++) spike(8'(a), 4'd1);
    chk("t5_acc", 256'(accepted_count), 256'(12));
    do_tick(1);
    read_request = 1'b1; clear_request = 1'b1; step();
    read_request = 1'b0; clear_request = 1'b0;
    chk("t5_act", axon_activity, 256'hFF);
    chk("t5_clear_done", 256'(clear_done), 256'(1));
    step();
    chk("t5_hold", axon_activity, 256'hFF);
    read_request = 1'b1; step(); read_request = 1'b0;
    chk("t5_reread", axon_activity, 256'(0));

    // Test 6: counter saturation, then asynchronous reset mid-stream
    spike_valid = 1'b1; spike_axon = 8'd9; spike_delay = 4'd1;
    repeat (65540) @(posedge clk);
    #1;
    chk("t6_sat", 256'(accepted_count), 256'(65535));
    tick = 1'b1; step(); tick = 1'b0;
    read_request = 1'b1; step(); read_request = 1'b0;
    exp_vec = 256'(1) << 9;
    chk("t6_act_pre", axon_activity, exp_vec);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_acc", 256'(accepted_count), 256'(0));
    chk("t6_rst_drop", 256'(dropped_count), 256'(0));
    chk("t6_rst_slot", 256'(cur_slot), 256'(0));
    chk("t6_rst_act", axon_activity, 256'(0));
    chk("t6_rst_valid", 256'(activity_valid), 256'(0));
    chk("t6_rst_ready", 256'(spike_ready), 256'(0));
    spike_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    do_tick(4);
    read_request = 1'b1; step(); read_request = 1'b0;
    chk("t6_ring_lost", axon_activity, 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
